// File: rtl/wbc_pkg.sv
// Shared types and helpers for the writeback trace checker.
// Holds the FSM encoding, the register-index width and the saturating counter step.
package wbc_pkg;

   localparam int RD_W = 5;

   typedef enum logic [1:0] {
      RUN  = 2'd0,
      HALT = 2'd1,
      OVF  = 2'd2
   } wbc_state_e;

   // Callers zero-extend their counter and pass its all-ones value as max.
   function automatic logic [63:0] sat_inc(input logic [63:0] v, input logic [63:0] max);
      return (v == max) ? v : v + 64'd1;
   endfunction

endpackage

// File: rtl/wbc_fifo.sv
// Show-ahead FIFO with count-based full/empty; a push into a full FIFO
// is accepted when a pop happens on the same edge.
module wbc_fifo
   import wbc_pkg::*;
#(
   parameter int WIDTH = 37,
   parameter int DEPTH = 16
)(
   input  logic             CLK,
   input  logic             flush,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic [AW:0]      count;
   logic             do_push, do_pop;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign dout    = mem[rd_ptr];

   // Storage carries no reset; validity is tracked by count alone.
   always_ff @(posedge CLK) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   always_ff @(posedge CLK) begin
      if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         if (do_push && !do_pop)      count <= count + 1'b1;
         else if (do_pop && !do_push) count <= count - 1'b1;
      end
   end

endmodule

// File: rtl/wb_trace_checker.sv
// In-order checker pairing core and golden writeback events through two FIFOs.
// Define WBC_FILTER_X0_EN to drop writes targeting x0 before they are queued.
module wb_trace_checker
   import wbc_pkg::*;
#(
   parameter int DATA_SIZE   = 32,
   parameter int DEPTH       = 16,
   parameter int CNT_W       = 16,
   parameter bit STOP_ON_ERR = 1'b1
)(
   input  logic                 CLK,
   input  logic                 RESET_N,
   input  logic                 CLEAR,
   input  logic                 dut_we,
   input  logic [RD_W-1:0]      dut_rd,
   input  logic [DATA_SIZE-1:0] dut_wdata,
   input  logic                 gold_we,
   input  logic [RD_W-1:0]      gold_rd,
   input  logic [DATA_SIZE-1:0] gold_wdata,
   output logic [CNT_W-1:0]     match_count,
   output logic [CNT_W-1:0]     mismatch_count,
   output logic                 error,
   output logic                 overflow,
   output logic [RD_W-1:0]      err_rd_dut,
   output logic [RD_W-1:0]      err_rd_gold,
   output logic [DATA_SIZE-1:0] err_data_dut,
   output logic [DATA_SIZE-1:0] err_data_gold,
   output logic [1:0]           state
);

   localparam int EW = RD_W + DATA_SIZE;

   wbc_state_e     st;
   logic           flush, pop, pair_match;
   logic           dut_req, gold_req, dut_ovf, gold_ovf;
   logic           dut_full, dut_empty, gold_full, gold_empty;
   logic [EW-1:0]  dut_head, gold_head;

   assign flush = !RESET_N || CLEAR;

`ifdef WBC_FILTER_X0_EN
   assign dut_req  = dut_we  && (dut_rd  != '0);
   assign gold_req = gold_we && (gold_rd != '0);
`else
   assign dut_req  = dut_we;
   assign gold_req = gold_we;
`endif

   assign pop        = (st == RUN) && !dut_empty && !gold_empty;
   assign pair_match = (dut_head == gold_head);
   assign dut_ovf    = dut_req  && dut_full  && !pop;
   assign gold_ovf   = gold_req && gold_full && !pop;
   assign state      = st;

   wbc_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_dut_fifo (
      .CLK(CLK), .flush(flush), .push(dut_req), .pop(pop),
      .din({dut_rd, dut_wdata}), .dout(dut_head),
      .full(dut_full), .empty(dut_empty)
   );

   wbc_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_gold_fifo (
      .CLK(CLK), .flush(flush), .push(gold_req), .pop(pop),
      .din({gold_rd, gold_wdata}), .dout(gold_head),
      .full(gold_full), .empty(gold_empty)
   );

   // Compare the popped pair, latch the first divergence, and steer the FSM.
   // An overflow on the same edge as a mismatch wins the state, but the
   // mismatch is still counted and captured.
   always_ff @(posedge CLK) begin
      if (flush) begin
         st             <= RUN;
         match_count    <= '0;
         mismatch_count <= '0;
         error          <= 1'b0;
         overflow       <= 1'b0;
         err_rd_dut     <= '0;
         err_rd_gold    <= '0;
         err_data_dut   <= '0;
         err_data_gold  <= '0;
      end else begin
         if (pop) begin
            if (pair_match) begin
               match_count <= CNT_W'(sat_inc(64'(match_count), 64'({CNT_W{1'b1}})));
            end else begin
               mismatch_count <= CNT_W'(sat_inc(64'(mismatch_count), 64'({CNT_W{1'b1}})));
               error          <= 1'b1;
               if (!error) begin
                  err_rd_dut    <= dut_head[EW-1 -: RD_W];
                  err_rd_gold   <= gold_head[EW-1 -: RD_W];
                  err_data_dut  <= dut_head[DATA_SIZE-1:0];
                  err_data_gold <= gold_head[DATA_SIZE-1:0];
               end
            end
         end
         if ((st == RUN) && (dut_ovf || gold_ovf)) begin
            st       <= OVF;
            overflow <= 1'b1;
         end else if (pop && !pair_match && STOP_ON_ERR) begin
            st <= HALT;
         end
      end
   end

endmodule

// File: tb/tb_wb_trace_checker.sv
// Directed self-checking bench for wb_trace_checker (default parameters).
// Expected values are hand-computed; x0 expectations follow WBC_FILTER_X0_EN.
module tb_wb_trace_checker;

   logic        CLK = 1'b0;
   logic        RESET_N = 1'b0;
   logic        CLEAR = 1'b0;
   logic        dut_we = 1'b0, gold_we = 1'b0;
   logic [4:0]  dut_rd = '0, gold_rd = '0;
   logic [31:0] dut_wdata = '0, gold_wdata = '0;
   logic [15:0] match_count, mismatch_count;
   logic        error, overflow;
   logic [4:0]  err_rd_dut, err_rd_gold;
   logic [31:0] err_data_dut, err_data_gold;
   logic [1:0]  state;

   int errors = 0;
   int checks = 0;

   wb_trace_checker dut (
      .CLK(CLK), .RESET_N(RESET_N), .CLEAR(CLEAR),
      .dut_we(dut_we), .dut_rd(dut_rd), .dut_wdata(dut_wdata),
      .gold_we(gold_we), .gold_rd(gold_rd), .gold_wdata(gold_wdata),
      .match_count(match_count), .mismatch_count(mismatch_count),
      .error(error), .overflow(overflow),
      .err_rd_dut(err_rd_dut), .err_rd_gold(err_rd_gold),
      .err_data_dut(err_data_dut), .err_data_gold(err_data_gold),
      .state(state)
   );

   always #5 CLK = ~CLK;

   // Present one edge's worth of inputs, changing them on the falling edge.
   task automatic applyStimulus(input logic dwe, input logic [4:0] drd, input logic [31:0] dd,
                                input logic gwe, input logic [4:0] grd, input logic [31:0] gd);
      @(negedge CLK);
      dut_we = dwe;  dut_rd = drd;  dut_wdata = dd;
      gold_we = gwe; gold_rd = grd; gold_wdata = gd;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
   endtask

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic doReset();
      @(negedge CLK);
      RESET_N = 1'b0;
      @(negedge CLK);
      RESET_N = 1'b1;
   endtask

   initial begin
      $display("[TB] start");
      doReset();
      checkOutput("rst_state", 64'(state), 64'd0);
      checkOutput("rst_match", 64'(match_count), 64'd0);
      checkOutput("rst_error", 64'(error), 64'd0);

      // Lockstep: rd=1..10, data=rd*3 on both sides together.
      for (int i = 1; i <= 10; i++) begin
         applyStimulus(1'b1, 5'(i), 32'(i*3), 1'b1, 5'(i), 32'(i*3));
         if (i == 2) checkOutput("lock_lat0", 64'(match_count), 64'd0);
         if (i == 3) checkOutput("lock_lat1", 64'(match_count), 64'd1);
      end
      idle(2);
      checkOutput("lock_match", 64'(match_count), 64'd10);
      checkOutput("lock_mism", 64'(mismatch_count), 64'd0);
      checkOutput("lock_error", 64'(error), 64'd0);
      checkOutput("lock_state", 64'(state), 64'd0);

      // Skew: golden on cycles 0-4, DUT with the same events on cycles 3-7.
      doReset();
      for (int c = 0; c < 8; c++) begin
         applyStimulus(c >= 3, 5'(c + 8), 32'(c * 17 + 1),
                       c <= 4, 5'(c + 11), 32'(c * 17 + 52));
      end
      idle(2);
      checkOutput("skew_match", 64'(match_count), 64'd5);
      checkOutput("skew_mism", 64'(mismatch_count), 64'd0);

      // Data mismatch on the third pair freezes the checker.
      doReset();
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b1, 5'(i + 5), (i == 2) ? 32'h55 : 32'(i + 5),
                       1'b1, 5'(i + 5), (i == 2) ? 32'h54 : 32'(i + 5));
      end
      idle(3);
      checkOutput("mm_match", 64'(match_count), 64'd2);
      checkOutput("mm_mism", 64'(mismatch_count), 64'd1);
      checkOutput("mm_error", 64'(error), 64'd1);
      checkOutput("mm_rd_dut", 64'(err_rd_dut), 64'd7);
      checkOutput("mm_rd_gold", 64'(err_rd_gold), 64'd7);
      checkOutput("mm_data_dut", 64'(err_data_dut), 64'h55);
      checkOutput("mm_data_gold", 64'(err_data_gold), 64'h54);
      checkOutput("mm_state", 64'(state), 64'd1);

      // Overflow: 16 golden events fill the FIFO, the 17th overflows.
      doReset();
      for (int i = 0; i < 16; i++) applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd1, 32'(i));
      applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd1, 32'd99);
      checkOutput("full_noovf", 64'(overflow), 64'd0);
      idle(1);
      checkOutput("ovf_flag", 64'(overflow), 64'd1);
      checkOutput("ovf_state", 64'(state), 64'd2);
      checkOutput("ovf_match", 64'(match_count), 64'd0);

      // CLEAR behaves like reset.
      @(negedge CLK);
      CLEAR = 1'b1;
      @(negedge CLK);
      CLEAR = 1'b0;
      checkOutput("clr_state", 64'(state), 64'd0);
      checkOutput("clr_ovf", 64'(overflow), 64'd0);

      // x0 write on the DUT side only, then a matching rd=3 pair.
      applyStimulus(1'b1, 5'd0, 32'hFFFF, 1'b0, 5'd0, 32'd0);
      applyStimulus(1'b1, 5'd3, 32'd9, 1'b1, 5'd3, 32'd9);
      idle(2);
`ifdef WBC_FILTER_X0_EN
      checkOutput("x0_match", 64'(match_count), 64'd1);
      checkOutput("x0_error", 64'(error), 64'd0);
`else
      checkOutput("x0_mism", 64'(mismatch_count), 64'd1);
      checkOutput("x0_error", 64'(error), 64'd1);
`endif

      // Reset mid-stream with 4 DUT events pending and one on the reset edge.
      for (int i = 0; i < 4; i++) applyStimulus(1'b1, 5'(i + 20), 32'(i), 1'b0, 5'd0, 32'd0);
      applyStimulus(1'b1, 5'd30, 32'hDEAD, 1'b0, 5'd0, 32'd0);
      RESET_N = 1'b0;
      applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      RESET_N = 1'b1;
      checkOutput("mrst_match", 64'(match_count), 64'd0);
      checkOutput("mrst_mism", 64'(mismatch_count), 64'd0);
      checkOutput("mrst_error", 64'(error), 64'd0);
      checkOutput("mrst_state", 64'(state), 64'd0);
      checkOutput("mrst_errrd", 64'({err_rd_dut, err_rd_gold}), 64'd0);
      checkOutput("mrst_errdata", {err_data_dut, err_data_gold}, 64'd0);
      applyStimulus(1'b1, 5'd4, 32'h1234, 1'b1, 5'd4, 32'h1234);
      idle(2);
      checkOutput("post_match", 64'(match_count), 64'd1);
      checkOutput("post_mism", 64'(mismatch_count), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/wb_trace_checker.md
# wb_trace_checker

Synthesizable in-order checker for register-writeback traces. It sits directly downstream of the pipelined core and the golden single-cycle model. It buffers each model's writeback events in its own FIFO and pairs them in retirement order, absorbing the pipeline's latency. It compares register index and data, and exposes match/mismatch counters plus a capture of the first divergence for the bench and for on-chip debug.

## Interface
Parameters:
- DATA_SIZE, 32, writeback data width
- DEPTH, 16, per-side FIFO entries (power of two, ≥2)
- CNT_W, 16, counter width
- STOP_ON_ERR, 1, 1 = freeze comparison after first mismatch

Ports:
- CLK  in  1  clock, all logic on rising edge
- RESET_N  in  1  synchronous, active-low reset
- CLEAR  in  1  synchronous clear, same effect as reset
- dut_we  in  1  pipelined core reg_write_enable
- dut_rd  in  5  pipelined core write_register
- dut_wdata  in  DATA_SIZE  pipelined core reg_write_data
- gold_we  in  1  golden reg_write_enable
- gold_rd  in  5  golden write_register
- gold_wdata  in  DATA_SIZE  golden reg_write_data
- match_count  out  CNT_W  compared pairs that matched
- mismatch_count  out  CNT_W  compared pairs that differed
- error  out  1  sticky, ≥1 mismatch seen
- overflow  out  1  sticky, an event was dropped on a full FIFO
- err_rd_dut, err_rd_gold  out  5  register indices of the first mismatching pair
- err_data_dut, err_data_gold  out  DATA_SIZE  data of the first mismatching pair
- state  out  2  current FSM state (encoding from package)

## Operation
- Push: each side is independent. A push occurs on an edge where we=1, subject to x0 filtering (see Configuration). It stores {rd, wdata}.
- FIFOs are show-ahead. A pop is both-sides simultaneous, and only when both are non-empty and state==RUN.
- Compare on pop: the pair matches iff rd equal and wdata equal. Match → match_count+1. Mismatch → mismatch_count+1 and error=1. On the first mismatch only, the err_* registers latch both sides.
- Counters saturate at all-ones; no wrap.
- FSM:
  - RUN: normal operation.
  - HALT: entered on a mismatch when STOP_ON_ERR=1. No pops; pushes continue until the FIFO is full, then extra events are dropped without setting overflow.
  - OVF: entered from RUN when a push hits a full FIFO. Sets overflow=1, drops the event, no further pops or compares.
  - HALT and OVF exit only via reset/CLEAR.
- Full rule: a push to a full FIFO is accepted if that FIFO pops on the same edge; otherwise it is an overflow (in RUN).
- Simultaneous mismatch and overflow on the same edge: go to OVF, but the mismatch is still counted and captured.
- Reset/CLEAR:
  - Both FIFOs are emptied.
  - All counters and err_* are set to 0; error=0, overflow=0, state=RUN.
  - Events presented on the reset edge are discarded.

## Timing
- Event pushed at edge N on both sides → popped and compared at edge N+1 → counters/error visible after edge N+1.
- If one side arrives k cycles after the other, the compare occurs at the edge after the later push.
- Back-to-back streaming at 1 pair/cycle is sustained with no bubbles.
- All outputs are registered; there are no combinational input→output paths.

## Configuration
- WBC_FILTER_X0_EN defined: events with rd==0 are never pushed (on either side). This matches cores that assert write-enable toward x0.
- WBC_FILTER_X0_EN undefined: x0 writes are pushed and compared like any other register.

## Structure
- Package wbc_pkg holds:
  - wbc_state_e {RUN=2'd0, HALT=2'd1, OVF=2'd2}
  - the RD_W=5 constant
  - the saturating-increment function
- Sub-module wbc_fifo: parameterized show-ahead FIFO (width, DEPTH) with count-based full/empty and same-cycle push+pop when full. It is instantiated twice, once for the DUT side and once for the golden side.

## Test plan
- Lockstep: 10 identical events (rd=1..10, data=rd*3) on both sides on the same cycles → match_count=10, mismatch_count=0, error=0, state=RUN.
- Skew: golden events on cycles 0–4, DUT same events on cycles 3–7 → compares complete at edges 4–8; match_count=5.
- Data mismatch, STOP_ON_ERR=1: 3rd pair has dut_wdata=0x55 vs gold 0x54, rd=7 →
  - match_count=2, mismatch_count=1
  - err_rd_dut=err_rd_gold=7, err_data_dut=0x55, err_data_gold=0x54
  - state=HALT; later pairs are not counted.
- Overflow: DEPTH=16, 17 golden events with no DUT events → overflow=1, state=OVF, match_count=0.
- x0 filter with WBC_FILTER_X0_EN defined: DUT writes rd=0 data=0xFFFF, golden writes nothing, then both write rd=3 data=9 → match_count=1, error=0. With the macro undefined, the same stimulus gives mismatch_count=1.
- Reset mid-stream: 4 DUT events pending, RESET_N=0 for one edge → all outputs zero, state=RUN, FIFOs empty. A subsequent matched pair gives match_count=1.
